// File: rtl/dice_roll_ctrl.sv
// Dice roll controller: button sync/debounce, free-running LFSR and decelerating tumble FSM.
// Optional DICE_ROLL_COUNT_EN adds an 8-bit completed-roll counter output.
module dice_roll_ctrl #(
    parameter int unsigned DEB_CYCLES = 1000000,
    parameter int unsigned TICK0      = 2500000,
    parameter int unsigned GROW       = 1250000,
    parameter int unsigned STEPS      = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn,
    output logic [2:0] face,
    output logic       face_valid,
    output logic       rolling
`ifdef DICE_ROLL_COUNT_EN
    ,
    output logic [7:0] roll_count
`endif
);

    localparam int unsigned DEB_W   = $clog2(DEB_CYCLES + 1);
    localparam int unsigned PER_MAX = TICK0 + GROW * (STEPS - 1);
    localparam int unsigned PER_W   = $clog2(PER_MAX + 1);
    localparam int unsigned STEP_W  = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_TUMBLE,
        S_DONE
    } state_t;

    logic              sync1_q, sync2_q;
    logic              deb_q, deb_d;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic              roll_req_q, roll_req_d;
    logic [7:0]        lfsr_q, lfsr_d;
    logic [2:0]        cand_c;
    state_t            state_q, state_d;
    logic [PER_W-1:0]  per_q, per_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [2:0]        face_q, face_d;
    logic              face_valid_q, face_valid_d;
    logic              rolling_q, rolling_d;

    // Debounce: accept a level only after DEB_CYCLES consecutive differing samples.
    always_comb begin
        deb_d      = deb_q;
        deb_cnt_d  = deb_cnt_q;
        roll_req_d = 1'b0;
        if (sync2_q != deb_q) begin
            if (deb_cnt_q == DEB_W'(DEB_CYCLES - 1)) begin
                deb_cnt_d  = '0;
                deb_d      = ~deb_q;
                roll_req_d = ~deb_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end else begin
            deb_cnt_d = '0;
        end
    end

    // x^8+x^6+x^5+x^4+1 Fibonacci LFSR, mapped onto a die face.
    assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign cand_c = 3'(lfsr_q % 8'd6) + 3'd1;

    always_comb begin
        state_d = state_q;
        per_d   = per_q;
        step_d  = step_q;
        face_d  = face_q;
        case (state_q)
            S_IDLE: begin
                if (roll_req_q) begin
                    state_d = S_TUMBLE;
                    step_d  = '0;
                    per_d   = PER_W'(TICK0 - 1);
                end
            end
            S_TUMBLE: begin
                if (per_q == '0) begin
                    // A step must always change the displayed face.
                    if (cand_c != face_q) begin
                        face_d = cand_c;
                    end else begin
                        face_d = (face_q == 3'd6) ? 3'd1 : face_q + 3'd1;
                    end
                    if (step_q == STEP_W'(STEPS - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        step_d = step_q + STEP_W'(1);
                        per_d  = PER_W'(TICK0 - 1 + GROW * (32'(step_q) + 32'd1));
                    end
                end else begin
                    per_d = per_q - PER_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        face_valid_d = (state_d == S_DONE);
        rolling_d    = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            deb_q        <= 1'b0;
            deb_cnt_q    <= '0;
            roll_req_q   <= 1'b0;
            lfsr_q       <= 8'hA5;
            state_q      <= S_IDLE;
            per_q        <= '0;
            step_q       <= '0;
            face_q       <= 3'd1;
            face_valid_q <= 1'b0;
            rolling_q    <= 1'b0;
        end else begin
            sync1_q      <= btn;
            sync2_q      <= sync1_q;
            deb_q        <= deb_d;
            deb_cnt_q    <= deb_cnt_d;
            roll_req_q   <= roll_req_d;
            lfsr_q       <= lfsr_d;
            state_q      <= state_d;
            per_q        <= per_d;
            step_q       <= step_d;
            face_q       <= face_d;
            face_valid_q <= face_valid_d;
            rolling_q    <= rolling_d;
        end
    end

    assign face       = face_q;
    assign face_valid = face_valid_q;
    assign rolling    = rolling_q;

`ifdef DICE_ROLL_COUNT_EN
    logic [7:0] roll_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            roll_cnt_q <= 8'd0;
        end else if (face_valid_d) begin
            roll_cnt_q <= roll_cnt_q + 8'd1;
        end
    end

    assign roll_count = roll_cnt_q;
`endif

endmodule

// File: doc/dice_roll_ctrl.md
Name: dice_roll_ctrl

Overview:
- Upstream control stage for the board dice display; drives the 3-bit face value consumed by the 7-segment decoder stage.
- Synchronises and debounces a raw push-button.
- On each debounced press, runs a decelerating "tumble" of pseudo-random faces 1..6, then settles on a final face and flags it valid.
- The free-running LFSR runs at full clk rate, so the outcome depends on press timing.

Parameters:
- DEB_CYCLES, 1000000, consecutive stable clk cycles required to accept a button level change (20 ms at 50 MHz).
- TICK0, 2500000, clk cycles before the first tumble step.
- GROW, 1250000, extra clk cycles added to each successive step period.
- STEPS, 12, number of tumble steps per roll; minimum 1.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- btn  input  1  raw roll push-button, asynchronous, active-high.
- face  output  3  current face value, always in 1..6.
- face_valid  output  1  one-cycle pulse when the final face is settled.
- rolling  output  1  high while a roll is in progress.

Behaviour:
- Reset (reset=0, asynchronous): face=1, face_valid=0, rolling=0, state IDLE, LFSR=8'hA5, debounced level=0, all counters 0. Release is synchronous to clk.
- Sync and debounce:
  - 2-flop synchroniser on btn.
  - Counter increments while the synchronised level differs from the debounced level; it clears whenever they match.
  - On reaching DEB_CYCLES-1, the debounced level flips and the counter clears.
  - roll_req is a one-cycle pulse on the debounced 0->1 edge. Latency from a btn edge is 2+DEB_CYCLES cycles.
- LFSR:
  - 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, shifts every clk cycle in every state. Never all-zero.
  - cand = (lfsr mod 6)+1, computed combinationally.
- State machine:
  - IDLE: rolling=0. On roll_req: go to TUMBLE, step_idx=0, period counter=TICK0-1, rolling=1 from the next cycle.
  - TUMBLE: period counter decrements each cycle. When it reaches 0, a step fires:
    - face <= cand if cand != face; otherwise face <= (face==6) ? 1 : face+1, so the face always visibly changes.
    - If step_idx==STEPS-1, go to DONE.
    - Otherwise step_idx++ and reload the period counter with TICK0+GROW*(step_idx+1)-1.
  - DONE: exactly 1 cycle. face_valid=1, rolling=1. Then IDLE.
- Total roll length:
  - From the roll_req cycle to the face_valid cycle: STEPS*TICK0 + GROW*STEPS*(STEPS-1)/2 + 1 cycles.
  - face is stable from the last step until the next roll.
- Boundary conditions:
  - roll_req in TUMBLE or DONE is ignored and not queued.
  - Button held down produces no repeat.
  - Reset mid-roll aborts immediately to the reset values above; no face_valid is emitted.
  - Period counter width is sized for TICK0+GROW*(STEPS-1) and must not overflow.
  - face never leaves 1..6. face_valid is never high for more than 1 cycle.

Optional Feature:
- Macro: DICE_ROLL_COUNT_EN.
- Defined:
  - Adds output roll_count [7:0], reset 0.
  - Increments by 1 in the DONE cycle; wraps 255->0.
  - Aborted rolls do not count.
- Undefined:
  - Port and counter are absent.
  - All other behaviour is identical.

Test Plan:
Bench parameters: DEB_CYCLES=4, TICK0=8, GROW=4, STEPS=3.
- Reset: hold reset=0 for 3 cycles with btn toggling -> face=1, face_valid=0, rolling=0 throughout; LFSR reads 8'hA5 after release.
- Single roll: clean btn 0->1 held 20 cycles -> roll_req 6 cycles after the edge; rolling=1; exactly 3 face changes at gaps of 8, 12 and 16 cycles; face_valid pulses 1 cycle, 37 cycles after roll_req; face in 1..6 and unchanged afterwards.
- Bounce rejection:
  - btn glitches high for 3 cycles, 3 times -> no roll_req, rolling stays 0.
  - Then held 10 cycles -> exactly one roll.
- Ignored press: second clean press during TUMBLE -> no restart, step timing unchanged, exactly one face_valid.
- Reset mid-roll: reset=0 during step 2 -> outputs return to reset values at once; no face_valid; a later press performs a full roll.
- 1000 rolls with random press timing:
  - Every face in 1..6; consecutive tumble faces always differ.
  - Each value 1..6 appears at least 100 times.
  - With DICE_ROLL_COUNT_EN defined, roll_count ends at 1000 mod 256 = 232.
